led_ring_tx: RTL and testbench
==============================

Name: led_ring_tx

Overview:
- Serial transmitter for the WS2812-style addressable pixel ring on the Cambridge display board. The pin is LEDRINGn, which is inverted on the board before it reaches the ring.
- It is the output-side counterpart of the button shift-register reader.
- It accepts RGB pixels over a valid/ready stream from the SoC fabric, serialises each pixel as 24 pulse-width-coded bits, and terminates each frame with a latch (reset) gap.
- It sits between the SoC interconnect and the top-level LEDRINGn pin.

Parameters:
- NUM_LEDS, 16, pixels per frame; the ring latches after this many pixels.
- T0H_CYC, 20, high time of a '0' bit in clock cycles (0.4 us at 50 MHz).
- T1H_CYC, 40, high time of a '1' bit in clock cycles (0.8 us).
- BIT_CYC, 63, total bit period in cycles (1.26 us). Must satisfy BIT_CYC > T1H_CYC.
- RESET_CYC, 2600, latch gap in cycles, line low (52 us).

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- pix_data  in  24  pixel {R[23:16], G[15:8], B[7:0]}.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  block can accept a pixel this cycle.
- led_ring_n  out  1  inverted serial data: 0 = ring line high, 1 = ring line low. Drives LEDRINGn.
- busy  out  1  high whenever state != IDLE or the holding register is full.
- frame_done  out  1  one-cycle pulse at the end of the latch gap.
- underrun  out  1  sticky flag: a frame was cut short because no pixel was ready.

Behaviour:
- Reset:
  - led_ring_n=1, pix_ready=1, busy=0, frame_done=0, underrun=0.
  - Holding register empty; state IDLE; all counters 0.
  - Reset applied mid-operation aborts immediately; the line is low from the next cycle.
- Holding register (one entry):
  - pix_ready = !hold_valid.
  - Transfer occurs on a clock edge where pix_valid && pix_ready. hold_valid is set after that edge.
  - The shifter loads from hold at each pixel boundary and clears hold_valid on the same edge. A simultaneous new transfer is not possible, because pix_ready was 0 that cycle.
- Byte reorder: the shifter is loaded with {G,R,B}. Transmission is MSB first, so the bit order is G7..G0, R7..R0, B7..B0.
- FSM states: IDLE, HIGH, LOW, LATCH.
  - IDLE: if hold_valid, load the shifter, set bit_cnt=23 and led_cnt=0, go to HIGH. From the accepting edge to led_ring_n=0 is 2 cycles.
  - HIGH: line high (led_ring_n=0) for exactly T1H_CYC cycles if the current bit is 1, or T0H_CYC cycles if it is 0. Then go to LOW.
  - LOW: line low for BIT_CYC − high time cycles, so every bit period is exactly BIT_CYC cycles. At the end of LOW:
    - If bit_cnt>0: shift left, decrement bit_cnt, go to HIGH.
    - Else if led_cnt==NUM_LEDS−1: go to LATCH.
    - Else if hold_valid: load the shifter, bit_cnt=23, led_cnt++, go to HIGH. There is no gap between pixels.
    - Else: set underrun=1 and go to LATCH.
  - LATCH: line low for RESET_CYC cycles. On the final cycle pulse frame_done for one cycle, then go to IDLE. led_cnt resets to 0.
    - pix_ready stays available during LATCH, so one pixel may be buffered.
    - The buffered pixel starts a new frame from IDLE (IDLE → HIGH on the next edge).
- underrun is sticky until reset. After an underrun the next pixel is LED 0 of a new frame.
- Counter widths:
  - Phase counter: $clog2(max(BIT_CYC, RESET_CYC)+1).
  - led_cnt: $clog2(NUM_LEDS+1).
  - bit_cnt: 5 bits.
  - No wrap-around occurs in normal operation.
- pix_data may change while pix_ready=0. Data is sampled only on a transfer edge.
- led_ring_n is driven from a register (glitch-free; no combinational path from inputs).

Test Plan:
1. Reset → led_ring_n=1, pix_ready=1, busy=0, frame_done=0, underrun=0. Hold these values for 100 cycles with pix_valid=0.
2. NUM_LEDS=1; send pix_data=24'h80_01_00 → 24 bits on the line in order 0x01,0x80,0x00.
   - Bit 7 (1-bit): 40 cycles low on led_ring_n, then 23 high.
   - 0-bits: 20 low, then 43 high.
   - Then 2600 cycles with led_ring_n=1, a frame_done pulse, and busy=0 afterwards.
3. Default NUM_LEDS=16; 16 pixels presented back-to-back with pix_valid held high →
   - Line activity lasts exactly 16×24×63 = 24192 cycles with no inter-pixel gap.
   - Exactly 16 transfers occur; one frame_done pulse; underrun=0.
4. Underrun: send 3 pixels, then idle → after pixel 3's last bit:
   - LATCH for 2600 cycles, underrun=1, frame_done pulses.
   - A 4th pixel then transmits as LED 0 of a new frame (led_cnt=0).
5. Reset mid-bit: assert reset for 1 cycle during HIGH of bit 10 of pixel 2 →
   - Next cycle led_ring_n=1, pix_ready=1, busy=0.
   - No further pulses occur until a new pixel is sent.
6. Backpressure: drive pix_valid continuously with an incrementing pattern, changed only after each transfer →
   - The scoreboard sees every pixel exactly once, in order.
   - pix_ready is low for the 24-bit duration minus the load slot.

Source files
------------

// File: rtl/led_ring_tx.sv
// rtl/led_ring_tx.sv - WS2812-style pixel ring serialiser with one-entry pixel holding register
module led_ring_tx #(
    parameter int NUM_LEDS  = 16,
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int RESET_CYC = 2600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        led_ring_n,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);
    localparam int PH_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int LC_W   = $clog2(NUM_LEDS + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [LC_W-1:0] led_cnt_q, led_cnt_d;
    logic [23:0]     shift_q, shift_d;
    logic [23:0]     hold_q;
    logic            hold_valid_q, hold_valid_d;
    logic            underrun_q, underrun_d;
    logic            frame_done_q, frame_done_d;
    logic            led_n_q;
    logic            hold_take;
    logic [PH_W-1:0] high_last, low_last;
    logic [23:0]     hold_grb;

    // The ring expects green first, so the pixel is reordered at load time
    assign hold_grb  = {hold_q[15:8], hold_q[23:16], hold_q[7:0]};
    assign high_last = shift_q[23] ? PH_W'(T1H_CYC - 1) : PH_W'(T0H_CYC - 1);
    assign low_last  = shift_q[23] ? PH_W'(BIT_CYC - T1H_CYC - 1) : PH_W'(BIT_CYC - T0H_CYC - 1);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_cnt_d    = bit_cnt_q;
        led_cnt_d    = led_cnt_q;
        shift_d      = shift_q;
        underrun_d   = underrun_q;
        frame_done_d = 1'b0;
        hold_take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    hold_take = 1'b1;
                    shift_d   = hold_grb;
                    bit_cnt_d = 5'd23;
                    led_cnt_d = '0;
                    phase_d   = '0;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (phase_q == high_last) begin
                    phase_d = '0;
                    state_d = LOW;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LOW: begin
                if (phase_q == low_last) begin
                    phase_d = '0;
                    if (bit_cnt_q != 5'd0) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        state_d   = HIGH;
                    end else if (led_cnt_q == LC_W'(NUM_LEDS - 1)) begin
                        state_d = LATCH;
                    end else if (hold_valid_q) begin
                        // Back-to-back pixel: next bit period starts with no gap
                        hold_take = 1'b1;
                        shift_d   = hold_grb;
                        bit_cnt_d = 5'd23;
                        led_cnt_d = led_cnt_q + 1'b1;
                        state_d   = HIGH;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = LATCH;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LATCH: begin
                if (phase_q == PH_W'(RESET_CYC - 1)) begin
                    phase_d      = '0;
                    led_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        if (hold_take) begin
            hold_valid_d = 1'b0;
        end else if (pix_valid && !hold_valid_q) begin
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            bit_cnt_q    <= '0;
            led_cnt_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
            led_n_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            led_cnt_q    <= led_cnt_d;
            shift_q      <= shift_d;
            hold_valid_q <= hold_valid_d;
            underrun_q   <= underrun_d;
            frame_done_q <= frame_done_d;
            // Registered from the current state so the pin never glitches
            led_n_q      <= (state_q != HIGH);
            if (pix_valid && !hold_valid_q) begin
                hold_q <= pix_data;
            end
        end
    end

    assign pix_ready  = !hold_valid_q;
    assign led_ring_n = led_n_q;
    assign busy       = (state_q != IDLE) || hold_valid_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_led_ring_tx.sv
// tb/tb_led_ring_tx.sv - scoreboard bench for led_ring_tx: line decoder checks every pixel and pulse timing
module tb_led_ring_tx;
    localparam int RESET_CYC = 2600;
    localparam int PIX_CYC   = 24 * 63;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] pix_data;
    logic        pix_valid, pix_ready, led_ring_n, busy, frame_done, underrun;
    logic [23:0] pix1_data;
    logic        pix1_valid, pix1_ready, led1_n, busy1, frame1_done, underrun1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] sb_q[$];
    int          xfer_cnt = 0;
    int          fd_cnt = 0;
    int          total_bits = 0;
    int          last_rdy_run = 0;
    bit          mon_hold = 1'b1;

    always #10 clock = ~clock;

    led_ring_tx u_dut (
        .clock(clock), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .led_ring_n(led_ring_n), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    led_ring_tx #(.NUM_LEDS(1)) u_dut1 (
        .clock(clock), .reset(reset), .pix_data(pix1_data), .pix_valid(pix1_valid),
        .pix_ready(pix1_ready), .led_ring_n(led1_n), .busy(busy1),
        .frame_done(frame1_done), .underrun(underrun1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [23:0] grb(input logic [23:0] p);
        return {p[15:8], p[23:16], p[7:0]};
    endfunction

    // Line decoder: high-pulse width gives the bit, 24 bits make a pixel
    initial begin : monitor
        logic        prev;
        logic        b;
        logic        last_bit;
        logic [23:0] shreg;
        int          run, nbits, rdy_run, fd_run;
        bit          seen;
        prev = 1'b1; b = 1'b0; last_bit = 1'b0; shreg = '0;
        run = 0; nbits = 0; rdy_run = 0; fd_run = 0; seen = 1'b0;
        forever begin
            @(negedge clock);
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_run++;
            end else begin
                if (fd_run != 0) check("frame_done_width", fd_run, 1);
                fd_run = 0;
            end
            if (pix_ready === 1'b0) begin
                rdy_run++;
            end else begin
                if (rdy_run != 0) last_rdy_run = rdy_run;
                rdy_run = 0;
            end
            if (mon_hold) begin
                prev = 1'b1; run = 0; nbits = 0; seen = 1'b0;
            end else if (led_ring_n === prev) begin
                run++;
            end else begin
                if (led_ring_n === 1'b0) begin
                    if (seen && run < 200) check("low_time", run, last_bit ? 23 : 43);
                end else begin
                    check("pulse_width_legal", (run == 20 || run == 40), 1);
                    b = (run == 40);
                    shreg = {shreg[22:0], b};
                    last_bit = b;
                    nbits++;
                    total_bits++;
                    seen = 1'b1;
                    if (nbits == 24) begin
                        nbits = 0;
                        if (sb_q.size() == 0) check("pixel_expected", 0, 1);
                        else check("pixel", shreg, sb_q.pop_front());
                    end
                end
                prev = led_ring_n;
                run = 1;
            end
        end
    end

    initial begin : xfer_counter
        forever begin
            @(posedge clock);
            if (pix_valid && pix_ready && !reset) xfer_cnt++;
        end
    end

    initial begin : watchdog
        #(200000 * 20);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    // Holds each pixel until accepted, then advances the incrementing pattern
    task automatic stream(input int n, input logic [23:0] base);
        int w;
        for (int k = 0; k < n; k++) begin
            pix_data  = base + 24'(k);
            pix_valid = 1'b1;
            w = 0;
            while (pix_ready !== 1'b1 && w < 5000) begin
                @(negedge clock);
                w++;
            end
            check("ready_wait", w < 5000, 1);
            @(posedge clock);
            sb_q.push_back(grb(base + 24'(k)));
            @(negedge clock);
        end
        pix_valid = 1'b0;
    endtask

    task automatic measure_frame(input string name, input int exp_span);
        int w, cnt;
        w = 0;
        while (led_ring_n !== 1'b0 && w < 10000) begin
            @(negedge clock);
            w++;
        end
        check({name, "_start"}, w < 10000, 1);
        cnt = 0;
        while (frame_done !== 1'b1 && cnt < 40000) begin
            @(negedge clock);
            cnt++;
        end
        check({name, "_span"}, cnt, exp_span);
    endtask

    initial begin : stim
        int          lat, hi, lo, cnt, zeros, xfer0, fd0, base_bits, w;
        logic [23:0] exp_w;
        logic        bexp;
        reset = 1'b1; pix_valid = 1'b0; pix_data = '0; pix1_valid = 1'b0; pix1_data = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("reset_outputs", {led_ring_n, pix_ready, busy, frame_done, underrun}, 5'b11000);
            check("reset_outputs_n1", {led1_n, pix1_ready, busy1, frame1_done, underrun1}, 5'b11000);
        end
        mon_hold = 1'b0;

        // Single-LED ring: 80_01_00 goes out as G=01, R=80, B=00
        exp_w = 24'h01_80_00;
        pix1_data  = 24'h80_01_00;
        pix1_valid = 1'b1;
        @(posedge clock);
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            pix1_valid = 1'b0;
            if (led1_n === 1'b0) break;
            lat++;
        end
        check("first_pulse_latency", lat, 2);
        for (int i = 0; i < 24; i++) begin
            bexp = exp_w[23 - i];
            hi = 1;
            for (int k = 0; k < 200; k++) begin
                @(negedge clock);
                if (led1_n !== 1'b0) break;
                hi++;
            end
            check("n1_high_time", hi, bexp ? 40 : 20);
            if (i < 23) begin
                lo = 1;
                for (int k = 0; k < 200; k++) begin
                    @(negedge clock);
                    if (led1_n !== 1'b1) break;
                    lo++;
                end
                check("n1_low_time", lo, bexp ? 23 : 43);
            end
        end
        cnt = 0; zeros = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            cnt++;
            if (led1_n !== 1'b1) zeros++;
            if (frame1_done === 1'b1) break;
        end
        check("n1_latch_to_frame_done", cnt, 43 + RESET_CYC - 1);
        check("n1_latch_line_low", zeros, 0);
        @(negedge clock);
        check("n1_after_frame", {frame1_done, busy1, led1_n}, 3'b001);

        // Full 16-pixel frame, back-to-back
        xfer0 = xfer_cnt; fd0 = fd_cnt;
        fork
            stream(16, 24'h10_20_30);
            measure_frame("full_frame", 16 * PIX_CYC + RESET_CYC - 1);
        join
        repeat (3) @(negedge clock);
        check("full_frame_transfers", xfer_cnt - xfer0, 16);
        check("full_frame_done_pulses", fd_cnt - fd0, 1);
        check("full_frame_underrun", underrun, 0);
        check("ready_low_run", last_rdy_run, PIX_CYC - 1);
        check("full_frame_idle_busy", busy, 0);

        // Three pixels then starvation
        fd0 = fd_cnt;
        fork
            stream(3, 24'hA0_B0_C0);
            measure_frame("underrun_frame", 3 * PIX_CYC + RESET_CYC - 1);
        join
        repeat (3) @(negedge clock);
        check("underrun_flag", underrun, 1);
        check("underrun_done_pulses", fd_cnt - fd0, 1);
        fd0 = fd_cnt;
        fork
            stream(16, 24'h00_FF_80);
            measure_frame("after_underrun", 16 * PIX_CYC + RESET_CYC - 1);
        join
        repeat (3) @(negedge clock);
        check("after_underrun_done_pulses", fd_cnt - fd0, 1);
        check("underrun_sticky", underrun, 1);

        // Reset during the high phase of bit 10 of the second pixel
        base_bits = total_bits;
        stream(2, 24'h55_AA_33);
        w = 0;
        while (!(total_bits >= base_bits + 34 && led_ring_n === 1'b0) && w < 5000) begin
            @(negedge clock);
            w++;
        end
        check("reach_bit10_px2", w < 5000, 1);
        mon_hold = 1'b1;
        reset = 1'b1;
        sb_q.delete();
        @(negedge clock);
        reset = 1'b0;
        check("mid_reset_outputs", {led_ring_n, pix_ready, busy, frame_done, underrun}, 5'b11000);
        zeros = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (led_ring_n !== 1'b1) zeros++;
        end
        check("quiet_after_reset", zeros, 0);
        check("idle_after_reset_busy", busy, 0);
        mon_hold = 1'b0;
        fork
            stream(1, 24'h0F_1E_2D);
            measure_frame("post_reset_frame", PIX_CYC + RESET_CYC - 1);
        join
        repeat (5) @(negedge clock);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
